// File: rtl/swo_nrz_tx.sv
// ============================================================================
// Module   : swo_nrz_tx
// Purpose  : NRZ (UART-style) SWO transmitter. Bytes arrive on a valid/ready
//            interface, queue in a small FIFO and leave on SWO as
//            start(0) + 8 data bits LSB-first + stop(1), each bit lasting
//            DIV_VAL+1 clock cycles (DIV_VAL latched at frame start).
// Ports    : CLK        - system clock
//            RESETn     - asynchronous active-low reset
//            TX_EN      - 1: frames may start; 0: finish current frame, idle
//            DIV_VAL    - bit period minus one, in CLK cycles
//            DATA_IN    - byte to send
//            DATA_VALID - DATA_IN valid
//            DATA_READY - FIFO not full
//            SWO        - serial line, idle high, driven from a flop
//            BUSY       - frame in progress or FIFO non-empty
//            FIFO_LEVEL - current FIFO occupancy
// Macro    : SWO_NRZ_TX_ITM_HDR_EN - when defined, every byte is preceded
//            by a complete 0x01 frame (ITM stimulus port 0, 1-byte header).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module swo_nrz_tx #(
  parameter int FIFO_DEPTH = 16,
  parameter int DIV_W      = 16
) (
  input  logic                        CLK,
  input  logic                        RESETn,
  input  logic                        TX_EN,
  input  logic [DIV_W-1:0]            DIV_VAL,
  input  logic [7:0]                  DATA_IN,
  input  logic                        DATA_VALID,
  output logic                        DATA_READY,
  output logic                        SWO,
  output logic                        BUSY,
  output logic [$clog2(FIFO_DEPTH):0] FIFO_LEVEL
);

  localparam int              c_AW      = $clog2(FIFO_DEPTH);
  localparam int              c_LW      = c_AW + 1;
  localparam logic [c_AW-1:0] c_PTR_ONE = c_AW'(1);
  localparam logic [c_LW-1:0] c_LVL_ONE = c_LW'(1);
  localparam logic [c_LW-1:0] c_FULL    = c_LW'(FIFO_DEPTH);
  localparam logic [DIV_W-1:0] c_DIV_ONE = DIV_W'(1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd3
`ifdef SWO_NRZ_TX_ITM_HDR_EN
    ,
    S_HDR   = 3'd4
`endif
  } state_t;

`ifdef SWO_NRZ_TX_ITM_HDR_EN
  // Header frame bits in transmit order (bit 0 first): start, 0x01, stop.
  localparam logic [9:0] c_HDR_FRAME   = {1'b1, 8'h01, 1'b0};
  localparam state_t     c_FIRST_STATE = S_HDR;
`else
  localparam state_t     c_FIRST_STATE = S_START;
`endif

  // --------------------------------------------------------------------------
  // Byte FIFO
  // --------------------------------------------------------------------------
  logic [7:0]      fifo_mem_q [FIFO_DEPTH];
  logic [c_AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [c_LW-1:0] level_q, level_d;
  logic            fifo_push, fifo_pop;
  logic [7:0]      fifo_head;

  // Ready depends only on the registered level, so a pop never reaches
  // DATA_READY combinationally.
  assign DATA_READY = (level_q != c_FULL);
  assign fifo_push  = DATA_VALID && DATA_READY;
  assign fifo_head  = fifo_mem_q[rd_ptr_q];

  always_ff @(posedge CLK) begin
    if (fifo_push) begin
      fifo_mem_q[wr_ptr_q] <= DATA_IN;
    end
  end

  always_comb begin
    level_d = level_q;
    case ({fifo_push, fifo_pop})
      2'b10:   level_d = level_q + c_LVL_ONE;
      2'b01:   level_d = level_q - c_LVL_ONE;
      default: level_d = level_q;
    endcase
  end

  // Pointers wrap naturally because FIFO_DEPTH is a power of two.
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (fifo_push) wr_ptr_q <= wr_ptr_q + c_PTR_ONE;
      if (fifo_pop)  rd_ptr_q <= rd_ptr_q + c_PTR_ONE;
      level_q <= level_d;
    end
  end

  // --------------------------------------------------------------------------
  // Serializer FSM
  // --------------------------------------------------------------------------
  state_t           state_q, state_d;
  logic [7:0]       shift_q, shift_d;
  logic [DIV_W-1:0] period_q, period_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [3:0]       bit_idx_q, bit_idx_d;
  logic             swo_q, swo_d;
  logic             can_start, bit_done, load_frame;

  assign can_start = TX_EN && (level_q != '0);
  assign bit_done  = (div_q == '0);

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      state_q   <= S_IDLE;
      shift_q   <= '0;
      period_q  <= '0;
      div_q     <= '0;
      bit_idx_q <= '0;
      swo_q     <= 1'b1;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      period_q  <= period_d;
      div_q     <= div_d;
      bit_idx_q <= bit_idx_d;
      swo_q     <= swo_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    period_d   = period_q;
    div_d      = div_q;
    bit_idx_d  = bit_idx_q;
    load_frame = 1'b0;
    fifo_pop   = 1'b0;
    swo_d      = 1'b1;

    case (state_q)
      S_IDLE: begin
        load_frame = can_start;
      end

      S_START: begin
        if (bit_done) begin
          state_d   = S_DATA;
          bit_idx_d = '0;
          div_d     = period_q;
        end else begin
          div_d = div_q - c_DIV_ONE;
        end
      end

      S_DATA: begin
        if (bit_done) begin
          div_d   = period_q;
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_idx_q == 4'd7) begin
            state_d = S_STOP;
          end else begin
            bit_idx_d = bit_idx_q + 4'd1;
          end
        end else begin
          div_d = div_q - c_DIV_ONE;
        end
      end

      S_STOP: begin
        if (bit_done) begin
          // Chaining straight into the next frame keeps exactly one stop bit.
          if (can_start) begin
            load_frame = 1'b1;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          div_d = div_q - c_DIV_ONE;
        end
      end

`ifdef SWO_NRZ_TX_ITM_HDR_EN
      // Whole 10-bit header frame lives in this state; bit_idx walks 0..9.
      S_HDR: begin
        if (bit_done) begin
          div_d = period_q;
          if (bit_idx_q == 4'd9) begin
            state_d   = S_START;
            bit_idx_d = '0;
          end else begin
            bit_idx_d = bit_idx_q + 4'd1;
          end
        end else begin
          div_d = div_q - c_DIV_ONE;
        end
      end
`endif

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // The popped byte waits in the shift register; with the header enabled
    // it is not shifted until the data frame's own START/DATA states.
    if (load_frame) begin
      fifo_pop  = 1'b1;
      shift_d   = fifo_head;
      period_d  = DIV_VAL;
      div_d     = DIV_VAL;
      bit_idx_d = '0;
      state_d   = c_FIRST_STATE;
    end

    // SWO is registered from the next state so the line changes on the same
    // edge the state does.
    case (state_d)
      S_START: swo_d = 1'b0;
      S_DATA:  swo_d = shift_d[0];
`ifdef SWO_NRZ_TX_ITM_HDR_EN
      S_HDR:   swo_d = c_HDR_FRAME[bit_idx_d];
`endif
      default: swo_d = 1'b1;
    endcase
  end

  assign SWO        = swo_q;
  assign BUSY       = (state_q != S_IDLE) || (level_q != '0);
  assign FIFO_LEVEL = level_q;

endmodule

`default_nettype wire
